// File: rtl/plotter_pkg.sv
// Shared plotter definitions: token layout, opcode values and Q8.8 constants.
// Imported by both the expression parser and the RPN evaluator.
package plotter_pkg;

   localparam int unsigned Q_INT_W      = 8;
   localparam int unsigned Q_FRAC_W     = 8;
   localparam int unsigned Q_NW         = Q_INT_W + Q_FRAC_W;

   // Token: bit Q_NW set means operator with opcode in the low OP_W bits.
   localparam int unsigned TOK_TYPE_BIT = Q_NW;
   localparam int unsigned OP_W         = 3;

   localparam logic [OP_W-1:0] OP_PLUS = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
   localparam logic [OP_W-1:0] OP_MUL  = 3'd2;
   localparam logic [OP_W-1:0] OP_DIV  = 3'd3;
   localparam logic [OP_W-1:0] OP_POW  = 3'd4;
   localparam logic [OP_W-1:0] OP_VAR  = 3'd6;

   localparam logic [Q_NW-1:0] ONE = 16'h0100;

endpackage

// File: rtl/rpn_evaluator_if.sv
// Evaluator bus: start/ready/result handshake with the sweep controller plus the
// token-queue read port. The evaluator uses the slave modport.
interface rpn_evaluator_if #(
   parameter int unsigned NW  = 16,
   parameter int unsigned QIW = 8
);
   logic           start;
   logic           ready;
   logic [NW-1:0]  x;
   logic [QIW-1:0] queue_length;
   logic           queue_read_en;
   logic [QIW-1:0] queue_index;
   logic [NW:0]    queue_data;
   logic           queue_data_valid;
   logic [NW-1:0]  result;
   logic           error;

   modport master (
      output start, x, queue_length, queue_data, queue_data_valid,
      input  ready, queue_read_en, queue_index, result, error
   );

   modport slave (
      input  start, x, queue_length, queue_data, queue_data_valid,
      output ready, queue_read_en, queue_index, result, error
   );
endinterface

// File: rtl/fixed_divider.sv
// Signed Q-format restoring divider: quotient = (a <<< FRAC) / b, truncated toward zero.
// One quotient bit per cycle over NW+FRAC cycles; start/done handshake.
module fixed_divider #(
   parameter int unsigned NW   = 16,
   parameter int unsigned FRAC = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [NW-1:0]           a,
   input  logic [NW-1:0]           b,
   output logic                    done,
   output logic                    div_by_zero,
   output logic signed [NW+FRAC:0] quotient
);
   localparam int unsigned DW = NW + FRAC;
   localparam int unsigned CW = $clog2(DW + 1);

   logic [NW-1:0] rem_q, rem_d, dvs_q, dvs_d, mag_a, mag_b;
   logic [DW-1:0] quo_q, quo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d, busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
   logic [NW:0]   trial, diff;

   assign mag_a = a[NW-1] ? -a : a;
   assign mag_b = b[NW-1] ? -b : b;
   assign trial = {rem_q, quo_q[DW-1]};
   // diff[NW] is the borrow: set when the trial remainder is below the divisor.
   assign diff  = trial - {1'b0, dvs_q};

   always_comb begin
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      quo_d  = quo_q;
      cnt_d  = cnt_q;
      neg_d  = neg_q;
      busy_d = busy_q;
      dbz_d  = dbz_q;
      done_d = 1'b0;
      if (start) begin
         if (b == '0) begin
            dbz_d  = 1'b1;
            done_d = 1'b1;
            busy_d = 1'b0;
         end else begin
            dbz_d  = 1'b0;
            busy_d = 1'b1;
            cnt_d  = CW'(DW);
            rem_d  = '0;
            quo_d  = {mag_a, {FRAC{1'b0}}};
            dvs_d  = mag_b;
            neg_d  = a[NW-1] ^ b[NW-1];
         end
      end else if (busy_q) begin
         if (!diff[NW]) begin
            rem_d = diff[NW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b1};
         end else begin
            rem_d = trial[NW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b0};
         end
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         neg_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         neg_q  <= neg_d;
         busy_q <= busy_d;
         done_q <= done_d;
         dbz_q  <= dbz_d;
      end
   end

   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign quotient    = neg_q ? $signed(-{1'b0, quo_q}) : $signed({1'b0, quo_q});

endmodule

// File: rtl/rpn_evaluator.sv
// Postfix token evaluator producing one signed Q8.8 result per start.
// Define RPN_EVALUATOR_SATURATE_EN to saturate add/sub/mul/div instead of wrapping.
module rpn_evaluator
   import plotter_pkg::*;
#(
   parameter int unsigned INTEGER_PART_WIDTH    = 8,
   parameter int unsigned FRACTIONAL_PART_WIDTH = 8,
   parameter int unsigned OUTPUT_QUEUE_SIZE     = 64,
   parameter int unsigned VALUE_STACK_SIZE      = 16
) (
   input logic            clk,
   input logic            rst,
   rpn_evaluator_if.slave bus_io
);
   localparam int unsigned NW   = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
   localparam int unsigned FRAC = FRACTIONAL_PART_WIDTH;
   localparam int unsigned QIW  = $clog2(OUTPUT_QUEUE_SIZE) + 2;
   localparam int unsigned SAW  = $clog2(VALUE_STACK_SIZE);
   localparam int unsigned SPW  = SAW + 1;
   localparam int unsigned DW   = NW + FRAC;
   localparam int unsigned EW   = INTEGER_PART_WIDTH;

   typedef enum logic [3:0] {
      StIdle, StFetch, StWait, StDecode, StDivRun, StPowRun, StNext, StCheck, StDone, StFail
   } state_e;

   function automatic logic [2*NW-1:0] sext(input logic [NW-1:0] v);
      return {{NW{v[NW-1]}}, v};
   endfunction

   function automatic logic [NW-1:0] fit(input logic signed [2*NW-1:0] v);
`ifdef RPN_EVALUATOR_SATURATE_EN
      if (v > $signed({{(NW+1){1'b0}}, {(NW-1){1'b1}}})) return {1'b0, {(NW-1){1'b1}}};
      if (v < $signed({{(NW+1){1'b1}}, {(NW-1){1'b0}}})) return {1'b1, {(NW-1){1'b0}}};
      return v[NW-1:0];
`else
      return v[NW-1:0];
`endif
   endfunction

   state_e          state_q, state_d;
   logic [NW-1:0]   x_q, x_d, result_q, result_d, acc_q, acc_d, base_q, base_d;
   logic [NW:0]     token_q, token_d;
   logic [SPW-1:0]  sp_q, sp_d;
   logic [QIW-1:0]  idx_q, idx_d;
   logic [EW-1:0]   cnt_q, cnt_d;
   logic            rd_en_q, rd_en_d, ready_q, ready_d, error_q, error_d;
   logic [NW-1:0]   stack_q [VALUE_STACK_SIZE];
   logic            stk_we;
   logic [SAW-1:0]  stk_waddr;
   logic [NW-1:0]   stk_wdata;
   logic            is_op;
   logic [OP_W-1:0] opcode;
   logic [NW-1:0]   op_a, op_b, add_res, sub_res, mul_res, div_res, pow_next;
   logic            div_start, div_done, div_dbz;
   logic signed [DW:0] div_quot;

   assign is_op    = token_q[NW];
   assign opcode   = token_q[OP_W-1:0];
   assign op_a     = stack_q[SAW'(sp_q - SPW'(2))];
   assign op_b     = stack_q[SAW'(sp_q - SPW'(1))];
   assign add_res  = fit(sext(op_a) + sext(op_b));
   assign sub_res  = fit(sext(op_a) - sext(op_b));
   assign mul_res  = fit($signed(sext(op_a) * sext(op_b)) >>> FRAC);
   assign div_res  = fit({{(2*NW-DW-1){div_quot[DW]}}, div_quot});
   assign pow_next = NW'($signed(sext(acc_q) * sext(base_q)) >>> FRAC);

   fixed_divider #(.NW(NW), .FRAC(FRAC)) u_div (
      .clk         (clk),
      .rst         (rst),
      .start       (div_start),
      .a           (op_a),
      .b           (op_b),
      .done        (div_done),
      .div_by_zero (div_dbz),
      .quotient    (div_quot)
   );

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      token_d   = token_q;
      sp_d      = sp_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      base_d    = base_q;
      rd_en_d   = 1'b0;
      ready_d   = ready_q;
      error_d   = error_q;
      result_d  = result_q;
      stk_we    = 1'b0;
      stk_waddr = SAW'(sp_q - SPW'(2));
      stk_wdata = '0;
      div_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               x_d     = bus_io.x;
               ready_d = 1'b0;
               error_d = 1'b0;
               idx_d   = '0;
               sp_d    = '0;
               if (bus_io.queue_length == '0) begin
                  state_d = StFail;
               end else begin
                  state_d = StFetch;
                  rd_en_d = 1'b1;
               end
            end
         end
         StFetch: state_d = StWait;
         StWait: begin
            if (bus_io.queue_data_valid) begin
               token_d = bus_io.queue_data;
               state_d = StDecode;
            end
         end
         StDecode: begin
            state_d = StNext;
            if (!is_op || opcode == OP_VAR) begin
               if (sp_q == SPW'(VALUE_STACK_SIZE)) begin
                  state_d = StFail;
               end else begin
                  stk_we    = 1'b1;
                  stk_waddr = SAW'(sp_q);
                  stk_wdata = is_op ? x_q : token_q[NW-1:0];
                  sp_d      = sp_q + SPW'(1);
               end
            end else if (opcode > OP_POW || sp_q < SPW'(2)) begin
               state_d = StFail;
            end else begin
               // Binary ops overwrite operand a in place; b's slot is released.
               case (opcode)
                  OP_PLUS: begin stk_we = 1'b1; stk_wdata = add_res; sp_d = sp_q - SPW'(1); end
                  OP_SUB:  begin stk_we = 1'b1; stk_wdata = sub_res; sp_d = sp_q - SPW'(1); end
                  OP_MUL:  begin stk_we = 1'b1; stk_wdata = mul_res; sp_d = sp_q - SPW'(1); end
                  OP_DIV:  begin div_start = 1'b1; state_d = StDivRun; end
                  default: begin
                     if (op_b[NW-1]) begin
                        state_d = StFail;
                     end else if (op_b[NW-1:FRAC] == '0) begin
                        stk_we    = 1'b1;
                        stk_wdata = NW'(ONE);
                        sp_d      = sp_q - SPW'(1);
                     end else begin
                        base_d  = op_a;
                        acc_d   = op_a;
                        cnt_d   = op_b[NW-1:FRAC] - EW'(1);
                        state_d = StPowRun;
                     end
                  end
               endcase
            end
         end
         StDivRun: begin
            if (div_done) begin
               if (div_dbz) begin
                  state_d = StFail;
               end else begin
                  stk_we    = 1'b1;
                  stk_wdata = div_res;
                  sp_d      = sp_q - SPW'(1);
                  state_d   = StNext;
               end
            end
         end
         StPowRun: begin
            if (cnt_q == '0) begin
               stk_we    = 1'b1;
               stk_wdata = acc_q;
               sp_d      = sp_q - SPW'(1);
               state_d   = StNext;
            end else begin
               acc_d = pow_next;
               cnt_d = cnt_q - EW'(1);
            end
         end
         StNext: begin
            idx_d = idx_q + QIW'(1);
            if (idx_d == bus_io.queue_length) begin
               state_d = StCheck;
            end else begin
               state_d = StFetch;
               rd_en_d = 1'b1;
            end
         end
         StCheck: begin
            if (sp_q == SPW'(1)) begin
               result_d = stack_q[0];
               state_d  = StDone;
            end else begin
               state_d = StFail;
            end
         end
         StDone: begin
            ready_d = 1'b1;
            state_d = StIdle;
         end
         StFail: begin
            error_d  = 1'b1;
            result_d = '0;
            ready_d  = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         x_q      <= '0;
         token_q  <= '0;
         sp_q     <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         base_q   <= '0;
         rd_en_q  <= 1'b0;
         ready_q  <= 1'b0;
         error_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         token_q  <= token_d;
         sp_q     <= sp_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         base_q   <= base_d;
         rd_en_q  <= rd_en_d;
         ready_q  <= ready_d;
         error_q  <= error_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && stk_we) stack_q[stk_waddr] <= stk_wdata;
   end

   assign bus_io.ready         = ready_q;
   assign bus_io.error         = error_q;
   assign bus_io.result        = result_q;
   assign bus_io.queue_read_en = rd_en_q;
   assign bus_io.queue_index   = idx_q;

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed bench for rpn_evaluator: a token RAM model with programmable read latency
// and hand-computed Q8.8 expectations for each step.
module tb_rpn_evaluator;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   lat_g;
   logic [16:0] mem [64];

   rpn_evaluator_if #(.NW(16), .QIW(8)) bus ();

   rpn_evaluator dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] tn(input logic [15:0] v);
      return {1'b0, v};
   endfunction

   function automatic logic [16:0] to(input logic [2:0] c);
      return {1'b1, 13'd0, c};
   endfunction

   // Token RAM: answers each read request after lat_g cycles.
   initial begin
      int cnt;
      int idx;
      cnt = 0;
      idx = 0;
      bus.queue_data       = '0;
      bus.queue_data_valid = 1'b0;
      forever begin
         @(negedge clk);
         bus.queue_data_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.queue_data       = mem[idx];
               bus.queue_data_valid = 1'b1;
            end
         end
         if (bus.queue_read_en) begin
            cnt = lat_g;
            idx = int'(bus.queue_index);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [15:0] xv, input int len, input int lat,
                      input logic [15:0] exp_r, input logic exp_e);
      int cyc;
      lat_g = lat;
      @(negedge clk);
      bus.x            = xv;
      bus.queue_length = 8'(len);
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.ready && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("%s/ready", tag), {31'd0, bus.ready}, 32'd1);
      chk($sformatf("%s/result", tag), {16'd0, bus.result}, {16'd0, exp_r});
      chk($sformatf("%s/error", tag), {31'd0, bus.error}, {31'd0, exp_e});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      lat_g    = 1;
      rst      = 1'b1;
      bus.start        = 1'b0;
      bus.x            = '0;
      bus.queue_length = '0;
      repeat (3) @(negedge clk);
      chk("rst/ready", {31'd0, bus.ready}, 32'd0);
      chk("rst/error", {31'd0, bus.error}, 32'd0);
      chk("rst/result", {16'd0, bus.result}, 32'd0);
      chk("rst/rd_en", {31'd0, bus.queue_read_en}, 32'd0);
      chk("rst/index", {24'd0, bus.queue_index}, 32'd0);
      rst = 1'b0;

      mem[0] = tn(16'h0200); mem[1] = tn(16'h0300); mem[2] = to(3'd0);
      run("add", 16'h0000, 3, 1, 16'h0500, 1'b0);
      for (int l = 2; l <= 5; l++) run($sformatf("add_lat%0d", l), 16'h0000, 3, l, 16'h0500, 1'b0);

      mem[0] = to(3'd6); mem[1] = to(3'd6); mem[2] = to(3'd2);
      run("mul_var", 16'h0180, 3, 1, 16'h0240, 1'b0);
      run("mul_var_lat3", 16'h0180, 3, 3, 16'h0240, 1'b0);

      mem[0] = tn(16'h0700); mem[1] = tn(16'h0200); mem[2] = to(3'd3);
      run("div", 16'h0000, 3, 1, 16'h0380, 1'b0);
      run("div_lat5", 16'h0000, 3, 5, 16'h0380, 1'b0);
      mem[0] = tn(16'hF900);
      run("div_neg", 16'h0000, 3, 1, 16'hFC80, 1'b0);
      mem[0] = tn(16'hFF00); mem[1] = tn(16'h0300);
      run("div_trunc", 16'h0000, 3, 2, 16'hFFAB, 1'b0);
      mem[0] = tn(16'h0700); mem[1] = tn(16'h0000);
      run("div_zero", 16'h0000, 3, 1, 16'h0000, 1'b1);

      mem[0] = tn(16'h0200); mem[1] = tn(16'h0300); mem[2] = to(3'd4);
      run("pow", 16'h0000, 3, 1, 16'h0800, 1'b0);
      mem[1] = tn(16'h0000);
      run("pow_zero", 16'h0000, 3, 1, 16'h0100, 1'b0);
      mem[1] = tn(16'hFF00);
      run("pow_neg", 16'h0000, 3, 1, 16'h0000, 1'b1);

      mem[0] = tn(16'h0100); mem[1] = tn(16'h0300); mem[2] = to(3'd1);
      run("sub", 16'h0000, 3, 1, 16'hFE00, 1'b0);
      mem[0] = tn(16'h7000); mem[1] = tn(16'h7000); mem[2] = to(3'd0);
`ifdef RPN_EVALUATOR_SATURATE_EN
      run("add_ovf", 16'h0000, 3, 1, 16'h7FFF, 1'b0);
`else
      run("add_ovf", 16'h0000, 3, 1, 16'hE000, 1'b0);
`endif
      mem[0] = tn(16'h7F00); mem[1] = tn(16'h0200); mem[2] = to(3'd2);
`ifdef RPN_EVALUATOR_SATURATE_EN
      run("mul_ovf", 16'h0000, 3, 1, 16'h7FFF, 1'b0);
`else
      run("mul_ovf", 16'h0000, 3, 1, 16'hFE00, 1'b0);
`endif

      mem[0] = tn(16'h0100); mem[1] = tn(16'h0100); mem[2] = to(3'd5);
      run("bad_op", 16'h0000, 3, 1, 16'h0000, 1'b1);
      mem[1] = to(3'd1);
      run("underflow", 16'h0000, 2, 1, 16'h0000, 1'b1);
      mem[0] = tn(16'h0200); mem[1] = tn(16'h0300); mem[2] = to(3'd0);
      run("add_again", 16'h0000, 3, 1, 16'h0500, 1'b0);
      run("two_nums", 16'h0000, 2, 1, 16'h0000, 1'b1);
      run("empty", 16'h0000, 0, 1, 16'h0000, 1'b1);

      for (int i = 0; i < 16; i++) mem[i] = tn(16'h0010);
      for (int i = 16; i < 31; i++) mem[i] = to(3'd0);
      run("stack_full", 16'h0000, 31, 1, 16'h0100, 1'b0);
      mem[16] = tn(16'h0010);
      run("overflow", 16'h0000, 17, 1, 16'h0000, 1'b1);

      // Abort a division partway through with rst, then evaluate a fresh queue.
      mem[0] = tn(16'h0700); mem[1] = tn(16'h0200); mem[2] = to(3'd3);
      lat_g = 1;
      @(negedge clk);
      bus.queue_length = 8'd3;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("abort/ready", {31'd0, bus.ready}, 32'd0);
      chk("abort/error", {31'd0, bus.error}, 32'd0);
      chk("abort/result", {16'd0, bus.result}, 32'd0);
      mem[0] = tn(16'h0100);
      run("after_abort", 16'h0000, 1, 1, 16'h0100, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
